// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared states and constants for the I2C master controller
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_NACK,
        S_STOP
    } state_t;

    localparam int PHASES_PER_BIT = 4;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// rtl/i2c_master_ctrl_if.sv - command/done handshake and open-drain line controls
interface i2c_master_ctrl_if;
    import i2c_pkg::*;

    logic       cmd_valid;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data_wr;
    logic [7:0] data_rd;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    modport master (
        input  cmd_valid, addr, rw, data_wr, scl_i, sda_i,
        output data_rd, busy, done, ack_err, scl_o, sda_o
    );

    modport slave (
        output cmd_valid, addr, rw, data_wr, scl_i, sda_i,
        input  data_rd, busy, done, ack_err, scl_o, sda_o
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-period divider with synchronous clear and hold
module i2c_tick_gen #(
    parameter int DIVIDE_BY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CW = $clog2(DIVIDE_BY);
    localparam logic [CW-1:0] LAST = CW'(DIVIDE_BY - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIVIDE_BY-1; a held count freezes so a stretched phase lasts longer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !hold;

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-transaction I2C master; I2C_CLK_STRETCH_EN enables clock stretching
module i2c_master_ctrl #(
    parameter int DIVIDE_BY = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_ctrl_if.master  bus
);
    import i2c_pkg::*;

    state_t     state, state_n;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] data_q;
    logic [7:0] rx_q;
    logic [7:0] data_rd_q;
    logic       ack_err_q;
    logic       done_q;

    logic       accept;
    logic       tick;
    logic       slot_end;
    logic       in_slot;
    logic       hold;
    logic       scl_n;
    logic       sda_n;
    logic [7:0] addr_byte;

    assign accept    = (state == S_IDLE) && bus.cmd_valid;
    assign slot_end  = tick && (phase == 2'(PHASES_PER_BIT - 1));
    assign in_slot   = state inside {S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_NACK};
    assign addr_byte = {addr_q, rw_q};

`ifdef I2C_CLK_STRETCH_EN
    assign hold = in_slot && ((phase == 2'd1) || (phase == 2'd2)) && !bus.scl_i;
`else
    logic unused_scl_i;
    assign hold         = 1'b0;
    assign unused_scl_i = bus.scl_i;
`endif

    i2c_tick_gen #(.DIVIDE_BY(DIVIDE_BY)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == S_IDLE),
        .hold  (hold),
        .tick  (tick)
    );

    // Next state: every non-idle state ends on the last quarter of its slot.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      if (accept) state_n = S_START;
            S_START:     if (slot_end) state_n = S_ADDR;
            S_ADDR:      if (slot_end && bit_cnt == 3'd0) state_n = S_ADDR_ACK;
            S_ADDR_ACK:  if (slot_end) state_n = ack_err_q ? S_STOP : ((rw_q == READ) ? S_READ : S_WRITE);
            S_WRITE:     if (slot_end && bit_cnt == 3'd0) state_n = S_WRITE_ACK;
            S_WRITE_ACK: if (slot_end) state_n = S_STOP;
            S_READ:      if (slot_end && bit_cnt == 3'd0) state_n = S_READ_NACK;
            S_READ_NACK: if (slot_end) state_n = S_STOP;
            S_STOP:      if (slot_end) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    // Line decode: bit slots pulse SCL high in q1/q2 and hold SDA for the whole slot.
    always_comb begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state)
            S_START: begin
                sda_n = !phase[1];
            end
            S_STOP: begin
                scl_n = (phase != 2'd0);
                sda_n = phase[1];
            end
            S_ADDR: begin
                scl_n = (phase == 2'd1) || (phase == 2'd2);
                sda_n = addr_byte[bit_cnt];
            end
            S_WRITE: begin
                scl_n = (phase == 2'd1) || (phase == 2'd2);
                sda_n = data_q[bit_cnt];
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ, S_READ_NACK: begin
                scl_n = (phase == 2'd1) || (phase == 2'd2);
            end
            default: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
        endcase
    end

    // State register plus command latch, phase/bit counters and SDA sampling at q1->q2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            bit_cnt   <= 3'd7;
            addr_q    <= 7'd0;
            rw_q      <= WRITE;
            data_q    <= 8'd0;
            rx_q      <= 8'd0;
            data_rd_q <= 8'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= 1'b0;
            if (accept) begin
                addr_q    <= bus.addr;
                rw_q      <= bus.rw;
                data_q    <= bus.data_wr;
                ack_err_q <= 1'b0;
                phase     <= 2'd0;
                bit_cnt   <= 3'd7;
            end else if (tick) begin
                phase <= phase + 2'd1;
                if (phase == 2'd1) begin
                    if ((state == S_ADDR_ACK || state == S_WRITE_ACK) && bus.sda_i)
                        ack_err_q <= 1'b1;
                    if (state == S_READ)
                        rx_q <= {rx_q[6:0], bus.sda_i};
                end
                if (slot_end) begin
                    bit_cnt <= (state_n != state) ? 3'd7 : bit_cnt - 3'd1;
                    if (state == S_STOP) begin
                        done_q <= 1'b1;
                        if (rw_q == READ && !ack_err_q)
                            data_rd_q <= rx_q;
                    end
                end
            end
        end
    end

    assign bus.scl_o   = scl_n;
    assign bus.sda_o   = sda_n;
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.data_rd = data_rd_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - randomized self-checking bench for i2c_master_ctrl
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic slave_sda = 1'b1;
    logic stretch_low = 1'b0;

    always #5 clk = ~clk;

    i2c_master_ctrl_if bus();

    assign bus.sda_i = bus.sda_o & slave_sda;
    assign bus.scl_i = bus.scl_o & ~stretch_low;

    i2c_master_ctrl #(.DIVIDE_BY(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       scl;
        logic       sda;
        logic       busy;
        logic       done;
        logic       slave;
        logic       stretch;
        logic [7:0] rd;
        logic       aerr;
    } cyc_t;

    typedef struct {
        logic scl;
        logic sda;
        logic slave;
    } ph_t;

    cyc_t exp_q[$];
    ph_t  ph_q[$];
    logic mon_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [7:0] model_rd = 8'h00;
    logic       model_aerr = 1'b0;
    logic       prev_scl = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp_v, $time);
    endtask

    // Per-cycle compare against the expected waveform; also plays the target's SDA and stretch.
    always @(negedge clk) begin
        cyc_t e;
        if (exp_q.size() > 0) begin
            if (!prev_scl && bus.scl_o) mon_q.push_back(bus.sda_i);
            e = exp_q.pop_front();
            chk("scl_o", bus.scl_o, e.scl);
            chk("sda_o", bus.sda_o, e.sda);
            chk("busy", bus.busy, e.busy);
            chk("done", bus.done, e.done);
            if (e.done) begin
                chk("data_rd_at_done", bus.data_rd, e.rd);
                chk("ack_err_at_done", bus.ack_err, e.aerr);
                model_rd   = e.rd;
                model_aerr = e.aerr;
            end
            slave_sda   = e.slave;
            stretch_low = e.stretch;
        end else begin
            chk("idle_scl", bus.scl_o, 1'b1);
            chk("idle_sda", bus.sda_o, 1'b1);
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_done", bus.done, 1'b0);
            chk("idle_data_rd", bus.data_rd, model_rd);
            chk("idle_ack_err", bus.ack_err, model_aerr);
            slave_sda   = 1'b1;
            stretch_low = 1'b0;
        end
        prev_scl = bus.scl_o;
    end

    task automatic add_phase(input logic scl, input logic sda, input logic slave);
        ph_t p;
        p.scl = scl; p.sda = sda; p.slave = slave;
        ph_q.push_back(p);
    endtask

    task automatic add_slot(input logic m, input logic s);
        add_phase(1'b0, m, s);
        add_phase(1'b1, m, s);
        add_phase(1'b1, m, s);
        add_phase(1'b0, m, s);
    endtask

    // Phase-level picture of the whole transaction from the bus protocol rules.
    task automatic build(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic aack, input logic dack, input logic [7:0] rb);
        logic [7:0] byt;
        byt = {a, r};
        ph_q.delete();
        add_phase(1, 1, 1); add_phase(1, 1, 1); add_phase(1, 0, 1); add_phase(1, 0, 1);
        for (int i = 7; i >= 0; i--) add_slot(byt[i], 1'b1);
        add_slot(1'b1, !aack);
        if (aack) begin
            if (!r) begin
                for (int i = 7; i >= 0; i--) add_slot(d[i], 1'b1);
                add_slot(1'b1, !dack);
            end else begin
                for (int i = 7; i >= 0; i--) add_slot(1'b1, rb[i]);
                add_slot(1'b1, 1'b1);
            end
        end
        add_phase(0, 0, 1); add_phase(1, 0, 1); add_phase(1, 1, 1); add_phase(1, 1, 1);
    endtask

    task automatic push_cyc(input ph_t p, input logic st);
        cyc_t c;
        c.scl = p.scl; c.sda = p.sda; c.busy = 1'b1; c.done = 1'b0;
        c.slave = p.slave; c.stretch = st; c.rd = 8'h00; c.aerr = 1'b0;
        exp_q.push_back(c);
    endtask

    // Each phase lasts D cycles; a stretch adds 10 cycles when stretching is built in.
    task automatic expand(input int stretch_phase, input logic [7:0] rd, input logic aerr);
        cyc_t c;
        int   left;
        left = 0;
        for (int k = 0; k < ph_q.size(); k++) begin
            if (k == stretch_phase) begin
`ifdef I2C_CLK_STRETCH_EN
                for (int j = 0; j < 10; j++) push_cyc(ph_q[k], 1'b1);
`else
                left = 10;
`endif
            end
            for (int j = 0; j < D; j++) begin
                push_cyc(ph_q[k], left > 0);
                if (left > 0) left--;
            end
        end
        c.scl = 1; c.sda = 1; c.busy = 0; c.done = 1; c.slave = 1; c.stretch = 0;
        c.rd = rd; c.aerr = aerr;
        exp_q.push_back(c);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() > 0 && n < 3000);
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL wait_idle: %0d expected cycles left after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input logic aack, input logic dack, input logic [7:0] rb,
                           input int stretch_phase, input int mid_cmd, input int rst_at,
                           output int n, output logic [7:0] mb0, output logic [7:0] mb1);
        logic [7:0] exp_rd;
        logic       exp_aerr;
        mb0 = 8'h00;
        mb1 = 8'h00;
        wait_idle();
        #1;
        bus.cmd_valid = 1'b1; bus.addr = a; bus.rw = r; bus.data_wr = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.addr = 7'($urandom); bus.rw = 1'($urandom); bus.data_wr = 8'($urandom);
        exp_rd   = (r && aack) ? rb : model_rd;
        exp_aerr = !aack || (!r && !dack);
        build(a, r, d, aack, dack, rb);
        expand(stretch_phase, exp_rd, exp_aerr);
        mon_q.delete();
        n = exp_q.size();
        if (mid_cmd > 0) begin
            repeat (mid_cmd - 1) @(posedge clk);
            #1;
            bus.cmd_valid = 1'b1; bus.addr = 7'($urandom); bus.rw = 1'($urandom);
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(posedge clk);
            #1;
            reset = 1'b1;
            exp_q.delete();
            model_rd = 8'h00;
            model_aerr = 1'b0;
            #1;
            chk("reset_scl", bus.scl_o, 1'b1);
            chk("reset_sda", bus.sda_o, 1'b1);
            chk("reset_busy", bus.busy, 1'b0);
            chk("reset_done", bus.done, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
        end else begin
            wait_idle();
            #2;
            chk("mon_bits", mon_q.size(), aack ? 19 : 10);
            if (mon_q.size() >= 10) begin
                for (int i = 0; i < 8; i++) mb0 = {mb0[6:0], mon_q[i]};
                chk("mon_addr_byte", mb0, {a, r});
                chk("mon_addr_ack", mon_q[8], !aack);
            end
            if (aack && mon_q.size() >= 19) begin
                for (int i = 9; i < 17; i++) mb1 = {mb1[6:0], mon_q[i]};
                chk("mon_data_byte", mb1, r ? rb : d);
                chk("mon_data_ack", mon_q[17], r ? 1'b1 : !dack);
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0] m0, m1;
        bus.cmd_valid = 1'b0; bus.addr = 7'd0; bus.rw = 1'b0; bus.data_wr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        run_txn(7'h50, 1'b0, 8'hA5, 1, 1, 8'h00, -1, 0, 0, n, m0, m1);
        chk("t1_done_cycle", n, 321);
        chk("t1_addr_byte", m0, 8'hA0);
        chk("t1_data_byte", m1, 8'hA5);
        chk("t1_ack_err", bus.ack_err, 1'b0);

        run_txn(7'h2A, 1'b1, 8'h00, 1, 1, 8'h3C, -1, 0, 0, n, m0, m1);
        chk("t2_addr_byte", m0, 8'h55);
        chk("t2_data_rd", bus.data_rd, 8'h3C);
        chk("t2_ack_err", bus.ack_err, 1'b0);

        run_txn(7'h11, 1'b1, 8'h77, 0, 1, 8'hFF, -1, 0, 0, n, m0, m1);
        chk("t3_done_cycle", n, 44 * D + 1);
        chk("t3_ack_err", bus.ack_err, 1'b1);
        chk("t3_data_rd_kept", bus.data_rd, 8'h3C);

        run_txn(7'h42, 1'b0, 8'h5A, 1, 0, 8'h00, -1, 0, 0, n, m0, m1);
        chk("t4_done_cycle", n, 80 * D + 1);
        chk("t4_ack_err", bus.ack_err, 1'b1);

        run_txn(7'h0F, 1'b0, 8'hC3, 1, 1, 8'h00, -1, 50, 0, n, m0, m1);
        chk("t5_ack_err", bus.ack_err, 1'b0);

        run_txn(7'h33, 1'b0, 8'h99, 1, 1, 8'h00, -1, 0, 100, n, m0, m1);

        run_txn(7'h21, 1'b0, 8'h3E, 1, 1, 8'h00, 17, 0, 0, n, m0, m1);
`ifdef I2C_CLK_STRETCH_EN
        chk("t7_stretch_done_cycle", n, 80 * D + 1 + 10);
`else
        chk("t7_nostretch_done_cycle", n, 80 * D + 1);
`endif

        for (int t = 0; t < 8; t++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
                    -1, 0, 0, n, m0, m1);
        end

        wait_idle();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
